// File: rtl/spi_sclk_engine.sv
// rtl/spi_sclk_engine.sv - SPI serial clock and framing engine; optional inter-transfer gap via SPI_SCLK_GAP_EN
module spi_sclk_engine #(
  parameter int SPPR_W   = 3,
  parameter int SPR_W    = 3,
  parameter int DIV_W    = 12,
  parameter int MAX_BITS = 16,
  localparam int BC_W    = $clog2(MAX_BITS) + 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [1:0]        spi_mode,
  input  logic              spiswai,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              start,
  input  logic [BC_W-1:0]   bit_count,
  output logic              busy,
  output logic              done,
  output logic              ss,
  output logic              sclk,
  output logic              sample_pulse,
  output logic              shift_pulse,
  output logic [DIV_W-1:0]  BaudRateDivisor
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_XFER  = 3'd2,
    S_TRAIL = 3'd3
`ifdef SPI_SCLK_GAP_EN
    , S_GAP = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              run_en;
  logic [DIV_W-1:0]  prescale;
  logic [SPR_W:0]    shamt;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  half_m1_q;
  logic [BC_W-1:0]   n_live;
  logic [BC_W-1:0]   lat_n;
  logic [BC_W:0]     edge_q;
  logic [BC_W:0]     edges_m1;
  logic              lat_cpol, lat_cpha;
  logic              sclk_q, done_q;
  logic              wrap, last_edge, accept, fire;

  // Wait mode only stalls the engine when stop-in-wait is enabled; stop modes always stall.
  assign run_en   = (spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai);
  assign prescale = DIV_W'(sppr) + DIV_W'(1);
  assign shamt    = {1'b0, spr} + {{SPR_W{1'b0}}, 1'b1};
  assign BaudRateDivisor = prescale << shamt;
  assign n_live   = (bit_count == '0) ? BC_W'(MAX_BITS) : bit_count;
  assign edges_m1 = {lat_n, 1'b0} - (BC_W+1)'(1);
  assign wrap      = (cnt_q == half_m1_q);
  assign last_edge = (edge_q == edges_m1);

  // Pulses announce the sclk edge that the register will produce at the next PCLK edge.
  assign fire         = run_en && (state_q == S_XFER) && wrap;
  assign sample_pulse = fire && (edge_q[0] == lat_cpha);
  assign shift_pulse  = fire && (edge_q[0] != lat_cpha);
  assign busy = (state_q != S_IDLE);
  assign ss   = !((state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL));
  assign sclk = sclk_q;
  assign done = done_q;

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; nothing advances while the engine is stalled.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (run_en) begin
      case (state_q)
        S_IDLE:  if (start) begin state_d = S_LEAD; accept = 1'b1; end
        S_LEAD:  if (wrap) state_d = S_XFER;
        S_XFER:  if (wrap && last_edge) state_d = S_TRAIL;
`ifdef SPI_SCLK_GAP_EN
        S_TRAIL: if (wrap) state_d = S_GAP;
        S_GAP:   if (wrap && edge_q[0]) state_d = S_IDLE;
`else
        S_TRAIL: if (wrap) state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Half-period counter, edge counter, sclk register, latched transfer settings and done.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q     <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
      half_m1_q <= '0;
      lat_n     <= '0;
      lat_cpol  <= 1'b0;
      lat_cpha  <= 1'b0;
    end else begin
      done_q <= (state_d == S_IDLE) && (state_q != S_IDLE);
      if (run_en) begin
        case (state_q)
          S_IDLE: begin
            cnt_q  <= '0;
            edge_q <= '0;
            sclk_q <= cpol;
            if (accept) begin
              half_m1_q <= {1'b0, BaudRateDivisor[DIV_W-1:1]} - DIV_W'(1);
              lat_n     <= n_live;
              lat_cpol  <= cpol;
              lat_cpha  <= cpha;
            end
          end
          S_XFER: begin
            if (wrap) begin
              cnt_q  <= '0;
              sclk_q <= ~sclk_q;
              edge_q <= last_edge ? '0 : edge_q + (BC_W+1)'(1);
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
`ifdef SPI_SCLK_GAP_EN
          S_GAP: begin
            sclk_q <= lat_cpol;
            cnt_q  <= wrap ? '0 : cnt_q + DIV_W'(1);
            if (wrap) edge_q <= edge_q + (BC_W+1)'(1);
          end
`endif
          default: begin
            sclk_q <= lat_cpol;
            edge_q <= '0;
            cnt_q  <= wrap ? '0 : cnt_q + DIV_W'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb/tb_spi_sclk_engine.sv - randomized self-checking bench for spi_sclk_engine
module tb_spi_sclk_engine;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [1:0] spi_mode = 2'b00;
  logic       spiswai = 1'b0;
  logic [2:0] sppr = '0;
  logic [2:0] spr = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       start = 1'b0;
  logic [4:0] bit_count = '0;
  logic       busy, done, ss, sclk, sample_pulse, shift_pulse;
  logic [11:0] BaudRateDivisor;

  int total_cnt = 0;
  int bad_cnt = 0;

  int r_busy, r_smp, r_shf, r_done, r_mis, r_mis_t, r_first, r_last;
  int r_edges, r_ss_gap, r_done_after, r_timeout;

  spi_sclk_engine dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .spi_mode(spi_mode), .spiswai(spiswai),
    .sppr(sppr), .spr(spr), .cpol(cpol), .cpha(cpha), .start(start),
    .bit_count(bit_count), .busy(busy), .done(done), .ss(ss), .sclk(sclk),
    .sample_pulse(sample_pulse), .shift_pulse(shift_pulse),
    .BaudRateDivisor(BaudRateDivisor)
  );

  always #5 PCLK = ~PCLK;

  // Run one transfer from an idle, post-edge point; record per-cycle deviations from the reference timeline.
  task automatic run_transfer(input int psp, input int ps, input int pc, input int pp, input int pb,
                              input int fr_at, input int fr_len, input int fr_mode, input int rnd_start);
    int h, n, total, last_t, t, cyc, fdone, ph, k;
    bit frz, e_busy, e_ss, e_sclk, e_smp, e_shf, e_done;
    logic prev_sclk;
    h = ((psp + 1) * (1 << (ps + 1))) / 2;
    n = (pb == 0) ? 16 : pb;
    total = 2 * h + 2 * n * h;
    last_t = total;
`ifdef SPI_SCLK_GAP_EN
    last_t = total + 2 * h;
`endif
    r_busy = 0; r_smp = 0; r_shf = 0; r_done = 0; r_mis = 0; r_mis_t = -1;
    r_first = 0; r_last = 0; r_edges = 0; r_ss_gap = 0; r_timeout = 0;
    sppr = 3'(psp); spr = 3'(ps); cpol = pc[0]; cpha = pp[0]; bit_count = 5'(pb);
    spi_mode = 2'b00; spiswai = 1'b0; start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    t = 0; cyc = 0; fdone = 0; prev_sclk = sclk;
    while (t <= last_t && cyc < 5000) begin
      frz = (fr_len > 0) && (t == fr_at) && (fdone < fr_len);
      if (frz) begin
        fdone++;
        if (fr_mode == 1) begin spi_mode = 2'b01; spiswai = 1'b1; end
        else spi_mode = 2'(fr_mode);
      end else if ($urandom_range(0, 1) == 1) begin
        spi_mode = 2'b00; spiswai = 1'($urandom_range(0, 1));
      end else begin
        spi_mode = 2'b01; spiswai = 1'b0;
      end
      start = (rnd_start != 0) && (t < last_t) && ($urandom_range(0, 5) == 0);
      @(negedge PCLK);
      e_smp = 0; e_shf = 0; e_sclk = pc[0];
      if (t < total) begin
        e_busy = 1; e_ss = 0; e_done = 0;
        if (t >= h && t < h + 2 * n * h) begin
          ph = (t - h) / h;
          e_sclk = pc[0] ^ ph[0];
          if ((t - h) % h == h - 1) begin
            k = ph + 1;
            if ((k % 2 == 1) == (pp == 0)) e_smp = 1; else e_shf = 1;
          end
        end
      end else if (t < last_t) begin
        e_busy = 1; e_ss = 1; e_done = 0;
      end else begin
        e_busy = 0; e_ss = 1; e_done = 1;
      end
      if (frz) begin e_smp = 0; e_shf = 0; end
      if (busy !== e_busy || ss !== e_ss || sclk !== e_sclk || done !== e_done ||
          sample_pulse !== e_smp || shift_pulse !== e_shf) begin
        r_mis++;
        if (r_mis_t < 0) r_mis_t = t;
      end
      if (busy === 1'b1) r_busy++;
      if (busy === 1'b1 && ss === 1'b1) r_ss_gap++;
      if (done === 1'b1) r_done++;
      if (sample_pulse === 1'b1) begin r_smp++; if (r_first == 0) r_first = 1; r_last = 1; end
      if (shift_pulse === 1'b1) begin r_shf++; if (r_first == 0) r_first = 2; r_last = 2; end
      if (sclk !== prev_sclk) r_edges++;
      prev_sclk = sclk;
      @(posedge PCLK); #1;
      if (!frz) t++;
      cyc++;
    end
    start = 1'b0; spi_mode = 2'b00; spiswai = 1'b0;
    if (cyc >= 5000) r_timeout = 1;
    @(negedge PCLK);
    r_done_after = (done === 1'b1) ? 1 : 0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset;
    PRESETn = 1'b0; cpol = 1'b1; sppr = 3'd2; spr = 3'd1;
    repeat (2) @(negedge PCLK);
    total_cnt++; if (sclk !== 1'b0) begin bad_cnt++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    total_cnt++; if (ss !== 1'b1) begin bad_cnt++; $display("FAIL reset_ss got=%b want=1", ss); end
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy got=%b want=0", busy); end
    total_cnt++; if (done !== 1'b0) begin bad_cnt++; $display("FAIL reset_done got=%b want=0", done); end
    total_cnt++; if (sample_pulse !== 1'b0 || shift_pulse !== 1'b0) begin
      bad_cnt++; $display("FAIL reset_pulses got=%b%b want=00", sample_pulse, shift_pulse); end
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_divisor;
    int a, b, want;
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(0, 7); b = $urandom_range(0, 7);
      sppr = 3'(a); spr = 3'(b);
      want = (a + 1) * (1 << (b + 1));
      #1;
      total_cnt++; if (BaudRateDivisor !== 12'(want)) begin
        bad_cnt++; $display("FAIL divisor sppr=%0d spr=%0d got=%0d want=%0d", a, b, BaudRateDivisor, want); end
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_idle;
    int busy_seen;
    for (int i = 0; i < 4; i++) begin
      cpol = i[0];
      @(posedge PCLK); #1;
      total_cnt++; if (sclk !== cpol) begin bad_cnt++; $display("FAIL idle_sclk got=%b want=%b", sclk, cpol); end
    end
    busy_seen = 0;
    for (int m = 0; m < 3; m++) begin
      if (m == 0) begin spi_mode = 2'b01; spiswai = 1'b1; end
      else spi_mode = 2'(m + 1);
      start = 1'b1;
      @(posedge PCLK); #1;
      start = 1'b0; spi_mode = 2'b00; spiswai = 1'b0;
      repeat (2) begin @(negedge PCLK); if (busy !== 1'b0) busy_seen++; end
      @(posedge PCLK); #1;
    end
    total_cnt++; if (busy_seen != 0) begin bad_cnt++; $display("FAIL stalled_start busy_cycles=%0d want=0", busy_seen); end
  endtask

  task automatic test_basic;
    int want_busy;
    want_busy = 144;
`ifdef SPI_SCLK_GAP_EN
    want_busy = 160;
`endif
    sppr = 3'd1; spr = 3'd2; #1;
    total_cnt++; if (BaudRateDivisor !== 12'd16) begin bad_cnt++; $display("FAIL basic_div got=%0d want=16", BaudRateDivisor); end
    run_transfer(1, 2, 0, 0, 8, 0, 0, 0, 1);
    total_cnt++; if (r_mis != 0) begin bad_cnt++; $display("FAIL basic_trace mismatches=%0d first_t=%0d want=0", r_mis, r_mis_t); end
    total_cnt++; if (r_busy != want_busy) begin bad_cnt++; $display("FAIL basic_busy got=%0d want=%0d", r_busy, want_busy); end
    total_cnt++; if (r_smp != 8 || r_shf != 8) begin bad_cnt++; $display("FAIL basic_pulses got=%0d/%0d want=8/8", r_smp, r_shf); end
    total_cnt++; if (r_edges != 16) begin bad_cnt++; $display("FAIL basic_edges got=%0d want=16", r_edges); end
    total_cnt++; if (r_done != 1 || r_done_after != 0) begin bad_cnt++; $display("FAIL basic_done got=%0d,%0d want=1,0", r_done, r_done_after); end
    total_cnt++; if (r_timeout != 0) begin bad_cnt++; $display("FAIL basic_timeout got=%0d want=0", r_timeout); end
  endtask

  task automatic test_cpol_cpha;
    cpol = 1'b1;
    @(posedge PCLK); #1;
    total_cnt++; if (sclk !== 1'b1) begin bad_cnt++; $display("FAIL cpol_idle got=%b want=1", sclk); end
    run_transfer(1, 2, 1, 1, 8, 0, 0, 0, 0);
    total_cnt++; if (r_mis != 0) begin bad_cnt++; $display("FAIL cpha_trace mismatches=%0d first_t=%0d want=0", r_mis, r_mis_t); end
    total_cnt++; if (r_first != 2 || r_last != 1) begin bad_cnt++; $display("FAIL cpha_order first=%0d last=%0d want=2,1", r_first, r_last); end
    total_cnt++; if (r_smp != 8 || r_shf != 8) begin bad_cnt++; $display("FAIL cpha_pulses got=%0d/%0d want=8/8", r_smp, r_shf); end
  endtask

  task automatic test_wait_freeze;
    int want_busy;
    want_busy = 164;
`ifdef SPI_SCLK_GAP_EN
    want_busy = 180;
`endif
    run_transfer(1, 2, 0, 0, 8, 40, 20, 1, 0);
    total_cnt++; if (r_mis != 0) begin bad_cnt++; $display("FAIL freeze_trace mismatches=%0d first_t=%0d want=0", r_mis, r_mis_t); end
    total_cnt++; if (r_busy != want_busy) begin bad_cnt++; $display("FAIL freeze_busy got=%0d want=%0d", r_busy, want_busy); end
    total_cnt++; if (r_smp != 8 || r_shf != 8) begin bad_cnt++; $display("FAIL freeze_pulses got=%0d/%0d want=8/8", r_smp, r_shf); end
  endtask

  task automatic test_reset_mid;
    int done_seen;
    sppr = 3'd1; spr = 3'd2; cpol = 1'b1; cpha = 1'b0; bit_count = 5'd8; start = 1'b1;
    @(posedge PCLK); #1;
    start = 1'b0;
    repeat (49) @(posedge PCLK);
    #3; PRESETn = 1'b0; #1;
    total_cnt++; if (ss !== 1'b1 || busy !== 1'b0 || sclk !== 1'b0) begin
      bad_cnt++; $display("FAIL abort_outputs ss=%b busy=%b sclk=%b want=1,0,0", ss, busy, sclk); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    done_seen = 0;
    @(posedge PCLK);
    @(negedge PCLK);
    total_cnt++; if (sclk !== 1'b1 || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL abort_release sclk=%b busy=%b want=1,0", sclk, busy); end
    for (int i = 0; i < 20; i++) begin @(negedge PCLK); if (done === 1'b1) done_seen++; end
    total_cnt++; if (done_seen != 0) begin bad_cnt++; $display("FAIL abort_done got=%0d want=0", done_seen); end
    @(posedge PCLK); #1;
  endtask

  task automatic test_min_div;
    run_transfer(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total_cnt++; if (r_mis != 0) begin bad_cnt++; $display("FAIL mindiv_trace mismatches=%0d first_t=%0d want=0", r_mis, r_mis_t); end
    total_cnt++; if (r_edges != 32) begin bad_cnt++; $display("FAIL mindiv_edges got=%0d want=32", r_edges); end
    total_cnt++; if (r_smp + r_shf != 32) begin bad_cnt++; $display("FAIL mindiv_pulses got=%0d want=32", r_smp + r_shf); end
  endtask

  task automatic test_random;
    int psp, ps, pb, n, h, tot, fa, fl, want_busy;
    for (int i = 0; i < 8; i++) begin
      psp = $urandom_range(0, 3); ps = $urandom_range(0, 3); pb = $urandom_range(0, 16);
      n = (pb == 0) ? 16 : pb;
      h = ((psp + 1) * (1 << (ps + 1))) / 2;
      tot = 2 * h + 2 * n * h;
      fa = $urandom_range(0, tot - 1); fl = $urandom_range(0, 10);
      want_busy = tot + fl;
`ifdef SPI_SCLK_GAP_EN
      want_busy = want_busy + 2 * h;
`endif
      run_transfer(psp, ps, $urandom_range(0, 1), $urandom_range(0, 1), pb, fa, fl, $urandom_range(1, 3), 1);
      total_cnt++; if (r_mis != 0 || r_timeout != 0) begin
        bad_cnt++; $display("FAIL rand%0d_trace mismatches=%0d first_t=%0d timeout=%0d want=0,0", i, r_mis, r_mis_t, r_timeout); end
      total_cnt++; if (r_busy != want_busy || r_smp != n || r_shf != n || r_done != 1) begin
        bad_cnt++; $display("FAIL rand%0d_counts busy=%0d smp=%0d shf=%0d done=%0d want=%0d,%0d,%0d,1",
                            i, r_busy, r_smp, r_shf, r_done, want_busy, n, n); end
    end
  endtask

`ifdef SPI_SCLK_GAP_EN
  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      run_transfer(1, 2, 0, 0, 8, 0, 0, 0, 1);
      total_cnt++; if (r_ss_gap != 16) begin bad_cnt++; $display("FAIL gap%0d_ss_high got=%0d want=16", i, r_ss_gap); end
      total_cnt++; if (r_mis != 0 || r_busy != 160) begin
        bad_cnt++; $display("FAIL gap%0d_trace mismatches=%0d busy=%0d want=0,160", i, r_mis, r_busy); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_divisor();
    test_idle();
    test_basic();
    test_cpol_cpha();
    test_wait_freeze();
    test_reset_mid();
    test_min_div();
    test_random();
`ifdef SPI_SCLK_GAP_EN
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
